// File: rtl/fc_act_packer_pkg.sv
// rtl/fc_act_packer_pkg.sv - activation codes and packer FSM states shared by the packer slice
package fc_act_packer_pkg;

  localparam logic [4:0] ACT_NONE  = 5'd0;
  localparam logic [4:0] ACT_RELU  = 5'd1;
  localparam logic [4:0] ACT_RELU6 = 5'd2;
  localparam logic [4:0] ACT_LEAKY = 5'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } pk_state_e;

  localparam int WORD_W  = 32;
  localparam int ENTRY_W = WORD_W + 1;

endpackage

// File: rtl/fc_out_fifo.sv
// rtl/fc_out_fifo.sv - synchronous first-word-fall-through FIFO for packed words
// Read data reads as zero while empty so the downstream bus idles at zero.
module fc_out_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fc_act_packer.sv
// rtl/fc_act_packer.sv - applies the layer activation to FC results and packs pairs into 32-bit words
// Packed words are buffered in fc_out_fifo and streamed out with a per-word last flag.
module fc_act_packer
  import fc_act_packer_pkg::*;
#(
  parameter int FRAC_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LEAKY_SHR  = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [11:0] cout_i,
  input  logic [4:0]  act_type_i,
  input  logic        din_valid_i,
  output logic        din_ready_o,
  input  logic [15:0] din_data_i,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic [31:0] dout_data_o,
  output logic        dout_last_o,
  output logic        done_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FIFO_FULL_C = CW'(FIFO_DEPTH);
  localparam logic signed [15:0] RELU6_MAX = 16'(6 << FRAC_BITS);

  pk_state_e state_q, state_d;
  logic [11:0] cout_q, cout_d;
  logic [11:0] cnt_q, cnt_d;
  logic [4:0]  act_q, act_d;
  logic [15:0] low_q, low_d;

  logic signed [15:0] x;
  logic signed [15:0] y;
  logic               accept;
  logic               is_final;
  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  // din_ready comes only from registered state so dout_ready never reaches it.
  assign din_ready_o = (state_q == S_RUN) && (fifo_count < FIFO_FULL_C);
  assign accept      = din_valid_i & din_ready_o;
  assign is_final    = (cnt_q == cout_q - 12'd1);

  always_comb begin
    x = din_data_i;
    y = x;
    case (act_q)
      ACT_RELU:  y = (x < 16'sd0) ? 16'sd0 : x;
      ACT_RELU6: begin
        if (x < 16'sd0)           y = 16'sd0;
        else if (x > RELU6_MAX)   y = RELU6_MAX;
        else                      y = x;
      end
      ACT_LEAKY: y = (x < 16'sd0) ? (x >>> LEAKY_SHR) : x;
      default:   y = x;
    endcase
  end

  // An odd element completes a pair; a lone final element is zero-padded in the high half.
  assign push      = accept & (cnt_q[0] | is_final);
  assign push_data = cnt_q[0] ? {is_final, y, low_q} : {is_final, 16'h0000, y};
  assign pop       = dout_valid_o & dout_ready_i;

  always_comb begin
    state_d = state_q;
    cout_d  = cout_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    low_d   = low_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cout_d  = cout_i;
          act_d   = act_type_i;
          cnt_d   = 12'd0;
          low_d   = 16'h0000;
          state_d = (cout_i == 12'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 12'd1;
          if (!cnt_q[0]) low_d = y;
          if (is_final)  state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cout_q  <= 12'd0;
      act_q   <= ACT_NONE;
      cnt_q   <= 12'd0;
      low_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cout_q  <= cout_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
    end
  end

  assign done_o = (state_q == S_DONE);

  fc_out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .rd_data_o   (fifo_rdata),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign dout_valid_o = ~fifo_empty;
  assign dout_last_o  = fifo_rdata[ENTRY_W-1];
  assign dout_data_o  = fifo_rdata[WORD_W-1:0];

endmodule

// File: tb/tb_fc_act_packer.sv
// tb/tb_fc_act_packer.sv - directed table-driven bench for fc_act_packer
module tb_fc_act_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] cout;
  logic [4:0]  act_type;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] din_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic        dout_last;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [32:0] got_q [$];

  always #5 clk = ~clk;

  fc_act_packer #(.FRAC_BITS(8), .FIFO_DEPTH(4), .LEAKY_SHR(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cout_i       (cout),
    .act_type_i   (act_type),
    .din_valid_i  (din_valid),
    .din_ready_o  (din_ready),
    .din_data_i   (din_data),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .dout_data_o  (dout_data),
    .dout_last_o  (dout_last),
    .done_o       (done)
  );

  // Records each word that will transfer on the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (dout_valid && dout_ready) got_q.push_back({dout_last, dout_data});
      if (done) done_cnt++;
    end
  end

  typedef struct {
    logic [4:0]  act;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [32:0] act_v, input logic [32:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  task automatic start_layer(input logic [11:0] n, input logic [4:0] a);
    start = 1'b1;
    cout = n;
    act_type = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] x);
    int t;
    t = 0;
    din_valid = 1'b1;
    din_data = x;
    while (!din_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: din_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int t;
    t = 0;
    while (done_cnt == base && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL done_timeout: done_cnt %0d, required > %0d", done_cnt, base);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [32:0] q_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 33'h1_DEAD_BEEF;
  endfunction

  initial begin
    int base;
    int acc;
    rst = 1'b1;
    start = 1'b0;
    cout = 12'd0;
    act_type = 5'd0;
    din_valid = 1'b0;
    din_data = 16'h0;
    dout_ready = 1'b1;

    vecs[0] = '{5'd0, 16'h0001, 16'h0002, 32'h0002_0001};
    vecs[1] = '{5'd2, 16'h0700, 16'h0500, 32'h0500_0600};
    vecs[2] = '{5'd3, 16'hFF00, 16'h0010, 32'h0010_FFE0};
    vecs[3] = '{5'd1, 16'hFF00, 16'h0100, 32'h0100_0000};
    vecs[4] = '{5'd7, 16'h8000, 16'h7FFF, 32'h7FFF_8000};
    vecs[5] = '{5'd2, 16'hF000, 16'h0600, 32'h0600_0000};
    vecs[6] = '{5'd3, 16'h8000, 16'h0001, 32'h0001_F000};
    vecs[7] = '{5'd1, 16'h7FFF, 16'h8001, 32'h0000_7FFF};

    repeat (2) @(negedge clk);
    chk("rst_din_ready", {32'd0, din_ready}, 33'd0);
    chk("rst_dout_valid", {32'd0, dout_valid}, 33'd0);
    chk("rst_dout_data", {1'b0, dout_data}, 33'd0);
    chk("rst_dout_last", {32'd0, dout_last}, 33'd0);
    chk("rst_done", {32'd0, done}, 33'd0);
    rst = 1'b0;
    @(negedge clk);

    // cout=4, passthrough
    got_q.delete();
    base = done_cnt;
    start_layer(12'd4, 5'd0);
    for (int i = 1; i <= 4; i++) feed(16'(i));
    wait_done(base);
    chk("t1_words", 33'(got_q.size()), 33'd2);
    chk("t1_w0", q_at(0), {1'b0, 32'h0002_0001});
    chk("t1_w1", q_at(1), {1'b1, 32'h0004_0003});
    chk("t1_done_once", 33'(done_cnt - base), 33'd1);

    // odd cout with ReLU
    got_q.delete();
    base = done_cnt;
    start_layer(12'd3, 5'd1);
    feed(16'hFF00);
    feed(16'h0100);
    feed(16'h8000);
    wait_done(base);
    chk("t2_words", 33'(got_q.size()), 33'd2);
    chk("t2_w0", q_at(0), {1'b0, 32'h0100_0000});
    chk("t2_w1", q_at(1), {1'b1, 32'h0000_0000});

    foreach (vecs[k]) begin
      got_q.delete();
      base = done_cnt;
      start_layer(12'd2, vecs[k].act);
      feed(vecs[k].d0);
      feed(vecs[k].d1);
      wait_done(base);
      chk($sformatf("vec%0d_words", k), 33'(got_q.size()), 33'd1);
      chk($sformatf("vec%0d_word", k), q_at(0), {1'b1, vecs[k].exp_word});
    end

    // backpressure: FIFO fills after 8 elements
    got_q.delete();
    base = done_cnt;
    dout_ready = 1'b0;
    start_layer(12'd16, 5'd0);
    acc = 0;
    din_valid = 1'b1;
    din_data = 16'd1;
    for (int c = 0; c < 20; c++) begin
      if (din_ready) begin
        @(negedge clk);
        acc++;
        din_data = 16'(acc + 1);
      end else begin
        @(negedge clk);
      end
    end
    din_valid = 1'b0;
    chk("t4_accepted", 33'(acc), 33'd8);
    chk("t4_din_ready_low", {32'd0, din_ready}, 33'd0);
    chk("t4_dout_valid", {32'd0, dout_valid}, 33'd1);
    dout_ready = 1'b1;
    for (int i = acc + 1; i <= 16; i++) feed(16'(i));
    wait_done(base);
    chk("t4_words", 33'(got_q.size()), 33'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t4_w%0d", i), q_at(i),
          {(i == 7), 16'(2 * i + 2), 16'(2 * i + 1)});

    // empty layer: done follows start directly, no output
    got_q.delete();
    base = done_cnt;
    start_layer(12'd0, 5'd0);
    #2;
    chk("t5_done_high", {32'd0, done}, 33'd1);
    @(negedge clk);
    #2;
    chk("t5_done_low", {32'd0, done}, 33'd0);
    repeat (3) @(negedge clk);
    chk("t5_no_words", 33'(got_q.size()), 33'd0);
    chk("t5_done_once", 33'(done_cnt - base), 33'd1);

    // start during RUN must be ignored
    got_q.delete();
    base = done_cnt;
    start_layer(12'd2, 5'd0);
    feed(16'h0005);
    start_layer(12'd0, 5'd1);
    feed(16'hFFF0);
    wait_done(base);
    chk("t5b_words", 33'(got_q.size()), 33'd1);
    chk("t5b_word", q_at(0), {1'b1, 32'hFFF0_0005});
    chk("t5b_done_once", 33'(done_cnt - base), 33'd1);

    // reset mid-layer drops everything
    dout_ready = 1'b0;
    start_layer(12'd8, 5'd0);
    feed(16'h0011);
    feed(16'h0022);
    feed(16'h0033);
    chk("t6_pre_valid", {32'd0, dout_valid}, 33'd1);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("t6_rst_valid", {32'd0, dout_valid}, 33'd0);
    chk("t6_rst_ready", {32'd0, din_ready}, 33'd0);
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    base = done_cnt;
    dout_ready = 1'b1;
    start_layer(12'd2, 5'd0);
    feed(16'h1111);
    feed(16'h2222);
    wait_done(base);
    chk("t6_words", 33'(got_q.size()), 33'd1);
    chk("t6_word", q_at(0), {1'b1, 32'h2222_1111});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
